// File: rtl/nccap_mul_pipe.sv
// Pipelined quadrant-decomposed approximate multiplier, 3 stages, per-transaction mode per partial product.
// Optional exact-error path and error counter are compiled in with `define APPROX_ERR_EN.
module nccap_mul_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [7:0]       in_cfg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_prod
`ifdef APPROX_ERR_EN
  ,
  output logic [2*W-1:0]   out_err,
  output logic [15:0]      err_cnt
`endif
);

  localparam int H   = W / 2;
  localparam int PW2 = 2 * W;
  localparam logic [W-1:0] TMASK = ~((W'(1) << TRUNC) - W'(1));

  generate
    if (LAT != 3) begin : g_bad_lat
      $error("nccap_mul_pipe: only LAT=3 is supported");
    end
    if ((W % 2) != 0 || W < 4) begin : g_bad_w
      $error("nccap_mul_pipe: W must be even and >= 4");
    end
    if (TRUNC < 0 || TRUNC > W - 1) begin : g_bad_trunc
      $error("nccap_mul_pipe: TRUNC must be in 0..W-1");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // One global enable stalls every stage together, so ready never depends on in_valid.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  function automatic logic [W-1:0] pp(input logic [H-1:0] x, input logic [H-1:0] y,
                                      input logic [1:0] m);
    logic [W-1:0] xe;
    logic [W-1:0] ye;
    logic [W-1:0] p;
    xe = W'(x);
    ye = W'(y);
    p  = '0;
    case (m)
      2'd0:    p = xe * ye;
      2'd1:    p = (xe * ye) & TMASK;
      2'd2:    p = (xe & ~W'(1)) * (ye & ~W'(1));
      default: p = '0;
    endcase
    return p;
  endfunction

  // Stage 1 registers
  logic [W-1:0] a1, b1;
  logic [7:0]   cfg1;
  logic         v1;

  // Stage 2 registers
  logic [W-1:0] ll2, lh2, hl2, hh2;
  logic         v2;

  logic [2*W-1:0] sum3;
  assign sum3 = {{W{1'b0}}, ll2}
              + (({{W{1'b0}}, lh2} + {{W{1'b0}}, hl2}) << H)
              + {hh2, {W{1'b0}}};

`ifdef APPROX_ERR_EN
  logic [2*W-1:0] ex2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1        <= '0;
      b1        <= '0;
      cfg1      <= '0;
      v1        <= 1'b0;
      ll2       <= '0;
      lh2       <= '0;
      hl2       <= '0;
      hh2       <= '0;
      v2        <= 1'b0;
      out_prod  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      a1        <= in_a;
      b1        <= in_b;
      cfg1      <= in_cfg;
      v1        <= in_valid;
      ll2       <= pp(a1[H-1:0], b1[H-1:0], cfg1[1:0]);
      lh2       <= pp(a1[H-1:0], b1[W-1:H], cfg1[3:2]);
      hl2       <= pp(a1[W-1:H], b1[H-1:0], cfg1[5:4]);
      hh2       <= pp(a1[W-1:H], b1[W-1:H], cfg1[7:6]);
      v2        <= v1;
      out_prod  <= sum3;
      out_valid <= v2;
    end
  end

`ifdef APPROX_ERR_EN
  // Every mode under-approximates, so exact - approximate never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex2     <= '0;
      out_err <= '0;
      err_cnt <= '0;
    end else begin
      if (en) begin
        ex2     <= PW2'(a1) * PW2'(b1);
        out_err <= ex2 - sum3;
      end
      if (out_valid && out_ready && (out_err != '0) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nccap_mul_pipe.sv
// Bench for nccap_mul_pipe: directed table, streaming stall, async reset, random traffic, W=16 instance.
// Compile with +define+APPROX_ERR_EN to also check out_err and err_cnt.
module tb_nccap_mul_pipe;
  localparam int W = 8;
  localparam int TRUNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]    in_a, in_b;
  logic [7:0]      in_cfg;
  logic [2*W-1:0]  out_prod;

  logic            in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]     in_a16, in_b16;
  logic [7:0]      in_cfg16;
  logic [31:0]     out_prod16;

`ifdef APPROX_ERR_EN
  logic [2*W-1:0]  out_err;
  logic [15:0]     err_cnt;
  logic [31:0]     out_err16;
  logic [15:0]     err_cnt16;
`endif

  nccap_mul_pipe #(.W(W), .TRUNC(TRUNC), .LAT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cfg(in_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
`ifdef APPROX_ERR_EN
    , .out_err(out_err), .err_cnt(err_cnt)
`endif
  );

  nccap_mul_pipe #(.W(16), .TRUNC(TRUNC), .LAT(3)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_cfg(in_cfg16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_prod(out_prod16)
`ifdef APPROX_ERR_EN
    , .out_err(out_err16), .err_cnt(err_cnt16)
`endif
  );

  int total = 0;
  int bad   = 0;
  int popped = 0;
  int model_err_cnt = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] experr_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint quad(input longint x, input longint y, input int m);
    case (m)
      0:       return x * y;
      1:       return (x * y) / (longint'(1) << TRUNC) * (longint'(1) << TRUNC);
      2:       return ((x / 2) * 2) * ((y / 2) * 2);
      default: return 0;
    endcase
  endfunction

  function automatic longint ref_prod(input longint a, input longint b, input int cfg, input int w);
    longint m, al, ah, bl, bh;
    m  = longint'(1) << (w / 2);
    al = a % m;  ah = a / m;
    bl = b % m;  bh = b / m;
    return quad(al, bl, cfg % 4)
         + (quad(al, bh, (cfg / 4) % 4) + quad(ah, bl, (cfg / 16) % 4)) * m
         + quad(ah, bh, (cfg / 64) % 4) * m * m;
  endfunction

  // ---------------- scoreboard / monitor (samples on negedge) ----------------
  logic           stall_prev = 1'b0;
  logic [2*W-1:0] held_prod;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_prod_held", out_prod, held_prod);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back((2*W)'(ref_prod(in_a, in_b, in_cfg, W)));
        experr_q.push_back((2*W)'(in_a * in_b - ref_prod(in_a, in_b, in_cfg, W)));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_prod, 'hdead);
        end else begin
          logic [2*W-1:0] e, ee;
          e  = exp_q.pop_front();
          ee = experr_q.pop_front();
          popped++;
          check("sb_prod", out_prod, e);
`ifdef APPROX_ERR_EN
          check("sb_err", out_err, ee);
`endif
          if (ee != 0) model_err_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held_prod  = out_prod;
    end
  end

  // ---------------- driver tasks (drive at posedge+1) ----------------
  task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] cfg, input logic [15:0] exp);
    int n;
    in_a = a; in_b = b; in_cfg = cfg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_prod"}, out_prod, exp);
    @(posedge clk); #1;
    check({name, "_pulse"}, out_valid, 0);
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] cfg, input logic [31:0] exp);
    int n;
    in_a16 = a; in_b16 = b; in_cfg16 = cfg; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 1;
    while (!out_valid16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_prod"}, out_prod16, exp);
    check({name, "_model"}, out_prod16, ref_prod(a, b, cfg, 16));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    experr_q.delete();
    model_err_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  cfg;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    int  idx, start_pop, n;
    logic fire;

    vt[0]  = '{8'hFF, 8'hFF, 8'h00, 16'hFE01};
    vt[1]  = '{8'h0F, 8'h0F, 8'h01, 16'h00E0};
    vt[2]  = '{8'h0F, 8'h0F, 8'h02, 16'h00C4};
    vt[3]  = '{8'h0F, 8'h0F, 8'h03, 16'h0000};
    vt[4]  = '{8'hF0, 8'hF0, 8'h40, 16'hE000};
    vt[5]  = '{8'h00, 8'h00, 8'h00, 16'h0000};
    vt[6]  = '{8'h00, 8'h00, 8'h55, 16'h0000};
    vt[7]  = '{8'h00, 8'h00, 8'hAA, 16'h0000};
    vt[8]  = '{8'h00, 8'h00, 8'hFF, 16'h0000};
    vt[9]  = '{8'hFF, 8'hFF, 8'hFF, 16'h0000};
    vt[10] = '{8'hFF, 8'hFF, 8'hAA, 16'hDD44};
    vt[11] = '{8'h12, 8'h34, 8'h55, 16'h0088};

    in_valid = 0; in_a = 0; in_b = 0; in_cfg = 0; out_ready = 1;
    in_valid16 = 0; in_a16 = 0; in_b16 = 0; in_cfg16 = 0; out_ready16 = 1;
    rst = 1'b1;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_prod", out_prod, 0);
    check("reset_in_ready", in_ready, 1);
`ifdef APPROX_ERR_EN
    check("reset_out_err", out_err, 0);
    check("reset_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cfg, vt[i].exp);
`ifdef APPROX_ERR_EN
    check("err_cnt_directed", err_cnt, model_err_cnt);
`endif

    // streaming with output stall on cycles 5..9
    idx = 0;
    start_pop = popped;
    for (int c = 0; c < 60; c++) begin
      if (idx == 8 && exp_q.size() == 0) break;
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (idx < 8);
      in_a      = 8'(idx);
      in_b      = 8'(idx + 1);
      in_cfg    = 8'h00;
      #1;
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    in_valid = 0; out_ready = 1;
    check("stream_sent", idx, 8);
    check("stream_received", popped - start_pop, 8);

    // async reset with pairs in flight
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(7 + i); in_b = 8'(9 + i); in_cfg = 8'h00;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("pre_reset_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_prod", out_prod, 0);
    check("async_rst_in_ready", in_ready, 1);
    exp_q.delete();
    experr_q.delete();
    model_err_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run_vec("post_reset", 8'd3, 8'd5, 8'h00, 16'd15);

    // random traffic with random backpressure
    in_valid = 0;
    fire = 0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = 8'($urandom_range(0, 255));
        in_b     = 8'($urandom_range(0, 255));
        in_cfg   = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
`ifdef APPROX_ERR_EN
    @(posedge clk); #1;
    check("err_cnt_final", err_cnt, model_err_cnt);
`endif

    // W=16 instance
    run16("w16_exact", 16'hFFFF, 16'hFFFF, 8'h00, 32'hFFFE0001);
    run16("w16_off",   16'hFFFF, 16'hFFFF, 8'hFF, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
